// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer: the FSM state
// encoding, the 2-bit opcode constants seen by the control unit, and helpers
// that locate the opcode field inside an instruction word of any width.
// Ports: none (package).
// ----------------------------------------------------------------------------
package fetch_pkg;

    // Sequencer states, one instruction takes FETCH -> LATCH -> EXEC
    typedef enum logic [1:0] {
        RST   = 2'b00,
        FETCH = 2'b01,
        LATCH = 2'b10,
        EXEC  = 2'b11
    } fetch_state_t;

    // Opcode field is two bits wide and sits at the top of the instruction
    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_R   = 2'b00;
    localparam logic [OP_W-1:0] OP_I   = 2'b01;
    localparam logic [OP_W-1:0] OP_RSV = 2'b10;
    localparam logic [OP_W-1:0] OP_J   = 2'b11;

    // Bit positions of the opcode field for a given instruction width
    function automatic int opFieldMsb(input int instrW);
        return instrW - 1;
    endfunction

    function automatic int opFieldLsb(input int instrW);
        return instrW - OP_W;
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// ----------------------------------------------------------------------------
// fetch_pc_next
// Combinational next-PC selection: either the jump target returned by the
// control unit or the current PC plus one, wrapping at 2^ADDR_W.
// Ports:
//   pc       in   ADDR_W  current program counter
//   jflag    in   1       jump request
//   jtarget  in   ADDR_W  jump destination
//   pc_next  out  ADDR_W  selected next program counter
// ----------------------------------------------------------------------------
module fetch_pc_next #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jflag,
    input  logic [ADDR_W-1:0] jtarget,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] w_pcInc;

    // The incrementer is exactly ADDR_W bits wide, so the carry out of the
    // top bit is dropped and the last address rolls over to zero.
    assign w_pcInc = pc + ADDR_W'(1);

    // A taken jump overrides sequential flow
    assign pc_next = jflag ? jtarget : w_pcInc;

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch sequencer. Owns the program counter, reads instruction
// memory (registered 1-cycle read), holds the instruction register and hands
// the opcode to the control unit. The jump flag coming back from the control
// unit chooses the next PC when the instruction leaves EXEC. Also counts
// retired instructions with a saturating counter.
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous active-high reset
//   imem_rd_en   out  1        memory read strobe (high in FETCH)
//   imem_addr    out  ADDR_W   memory read address, equal to pc
//   imem_rdata   in   INSTR_W  memory read data, captured only in LATCH
//   stall        in   1        hold the current instruction in EXEC
//   jflag        in   1        jump request, sampled only in EXEC
//   jtarget      in   ADDR_W   jump destination, sampled with jflag
//   instr        out  INSTR_W  instruction register
//   opcode       out  2        top two bits of instr
//   instr_valid  out  1        instr/opcode valid for execution (EXEC)
//   pc           out  ADDR_W   address of instr
//   retired      out  CNT_W    completed instruction count, saturating
// ----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               jflag,
    input  logic [ADDR_W-1:0]  jtarget,
    output logic [INSTR_W-1:0] instr,
    output logic [1:0]         opcode,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   retired
);

    localparam int OP_MSB = opFieldMsb(INSTR_W);
    localparam int OP_LSB = opFieldLsb(INSTR_W);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_retired;
    logic               r_instrValid;
    logic               r_rdEn;
    logic [ADDR_W-1:0]  w_pcNext;

    // Next-PC mux and wrapping incrementer
    fetch_pc_next #(
        .ADDR_W (ADDR_W)
    ) u_pcNext (
        .pc      (r_pc),
        .jflag   (jflag),
        .jtarget (jtarget),
        .pc_next (w_pcNext)
    );

    // Sequencer FSM together with the PC, instruction register and retired
    // counter. The read strobe and instr_valid are registered: each is set on
    // the edge that enters the state where it must be high, so they line up
    // exactly with FETCH and EXEC. Reset has priority in every state, which
    // also throws away a pending jump and suppresses a LATCH capture. While
    // stalled in EXEC nothing is updated, so jflag/jtarget are ignored until
    // the first non-stalled EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RST;
            r_pc         <= '0;
            r_instr      <= '0;
            r_retired    <= '0;
            r_instrValid <= 1'b0;
            r_rdEn       <= 1'b0;
        end else begin
            case (r_state)
                RST: begin
                    r_state <= FETCH;
                    r_rdEn  <= 1'b1;
                end
                FETCH: begin
                    r_state <= LATCH;
                    r_rdEn  <= 1'b0;
                end
                LATCH: begin
                    r_state      <= EXEC;
                    r_instr      <= imem_rdata;
                    r_instrValid <= 1'b1;
                end
                EXEC: begin
                    if (!stall) begin
                        r_state      <= FETCH;
                        r_pc         <= w_pcNext;
                        r_instrValid <= 1'b0;
                        r_rdEn       <= 1'b1;
                        if (r_retired != '1) begin
                            r_retired <= r_retired + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= RST;
                end
            endcase
        end
    end

    assign imem_rd_en  = r_rdEn;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[OP_MSB:OP_LSB];
    assign instr_valid = r_instrValid;
    assign pc          = r_pc;
    assign retired     = r_retired;

endmodule
